// File: rtl/mips_irq_pkg.sv
// Shared definitions for the interrupt controller: FSM encoding, default sizes, source indices.
// Pure declarations, no logic.
package mips_irq_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'b00,
    REQ     = 2'b01,
    SERVICE = 2'b10
  } irq_state_e;

  localparam int IRQ_NUM_SRC = 8;
  localparam int IRQ_VEC_W   = 3;

  localparam int IRQ_TIMER   = 0;
  localparam int IRQ_UART_RX = 1;
  localparam int IRQ_UART_TX = 2;

endpackage

// File: rtl/irq_prio_enc.sv
// Fixed-priority encoder: lowest set request index wins, valid when any bit is set.
// Purely combinational, zero latency, no backpressure.
module irq_prio_enc
  import mips_irq_pkg::*;
#(
  parameter int NUM_SRC = IRQ_NUM_SRC,
  parameter int VEC_W   = IRQ_VEC_W
) (
  input  logic [NUM_SRC-1:0] req,
  output logic [VEC_W-1:0]   idx,
  output logic               valid
);

  always_comb begin
    idx   = '0;
    valid = |req;
    // Scan from the top so the lowest set index is the last to overwrite idx.
    for (int i = NUM_SRC - 1; i >= 0; i--) begin
      if (req[i]) begin
        idx = VEC_W'(i);
      end
    end
  end

endmodule

// File: rtl/irq_ctrl.sv
// Interrupt controller: edge/level capture, mask, fixed priority, req/ack/eoi handshake to Control.
// Source edge to irq is 2 cycles; no new request while a handler runs or in kernel mode.
module irq_ctrl
  import mips_irq_pkg::*;
#(
  parameter int                 NUM_SRC    = IRQ_NUM_SRC,
  parameter int                 VEC_W      = IRQ_VEC_W,
  parameter logic [NUM_SRC-1:0] LEVEL_MODE = '0
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NUM_SRC-1:0] src,
  input  logic               in_kernel,
  input  logic               mask_we,
  input  logic [NUM_SRC-1:0] mask_wdata,
  input  logic               irq_ack,
  input  logic               eoi,
  output logic               irq,
  output logic [VEC_W-1:0]   irq_vec,
  output logic [NUM_SRC-1:0] mask,
  output logic [NUM_SRC-1:0] pending,
  output logic [NUM_SRC-1:0] overrun
);

  localparam int VEC_N = 1 << VEC_W;

  irq_state_e         state_q, state_d;
  logic               irq_q, irq_d;
  logic [VEC_W-1:0]   irq_vec_q, irq_vec_d;
  logic [NUM_SRC-1:0] mask_q, mask_d;
  logic [NUM_SRC-1:0] pending_q, pending_d;
  logic [NUM_SRC-1:0] overrun_q, overrun_d;
  logic [NUM_SRC-1:0] src_prev_q, src_prev_d;

  logic [NUM_SRC-1:0] rise;
  logic [NUM_SRC-1:0] eligible;
  logic [NUM_SRC-1:0] ack_clr;
  logic [VEC_N-1:0]   elig_ext;
  logic [VEC_N-1:0]   clr_ext;
  logic [VEC_W-1:0]   win_idx;
  logic               win_vld;

  assign eligible = pending_q & mask_q;

  irq_prio_enc #(
    .NUM_SRC(NUM_SRC),
    .VEC_W  (VEC_W)
  ) u_prio_enc (
    .req  (eligible),
    .idx  (win_idx),
    .valid(win_vld)
  );

  // Capture path. A fresh edge beats the ack clear on the same bit, and the
  // overrun flag is only raised by an edge the ack does not consume.
  always_comb begin
    rise     = src & ~src_prev_q;
    elig_ext = '0;
    elig_ext[NUM_SRC-1:0] = eligible;
    clr_ext  = '0;
    clr_ext[irq_vec_q] = (state_q == REQ) && irq_ack;
    ack_clr  = clr_ext[NUM_SRC-1:0];

    src_prev_d = src;
    mask_d     = mask_we ? mask_wdata : mask_q;
    pending_d  = (LEVEL_MODE & src) |
                 (~LEVEL_MODE & ((pending_q & ~ack_clr) | rise));
    overrun_d  = ~LEVEL_MODE & ~ack_clr & (overrun_q | (rise & pending_q));
  end

  always_comb begin
    state_d   = state_q;
    irq_d     = irq_q;
    irq_vec_d = irq_vec_q;
    case (state_q)
      IDLE: begin
        irq_d = 1'b0;
        if (win_vld && !in_kernel) begin
          state_d   = REQ;
          irq_d     = 1'b1;
          irq_vec_d = win_idx;
        end
      end
      REQ: begin
        if (irq_ack) begin
          state_d = SERVICE;
          irq_d   = 1'b0;
        end else if (!elig_ext[irq_vec_q]) begin
          state_d = IDLE;
          irq_d   = 1'b0;
        end
      end
      SERVICE: begin
        irq_d = 1'b0;
        if (eoi) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
        irq_d   = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      irq_q      <= 1'b0;
      irq_vec_q  <= '0;
      mask_q     <= '0;
      pending_q  <= '0;
      overrun_q  <= '0;
      src_prev_q <= '0;
    end else begin
      state_q    <= state_d;
      irq_q      <= irq_d;
      irq_vec_q  <= irq_vec_d;
      mask_q     <= mask_d;
      pending_q  <= pending_d;
      overrun_q  <= overrun_d;
      src_prev_q <= src_prev_d;
    end
  end

  assign irq     = irq_q;
  assign irq_vec = irq_vec_q;
  assign mask    = mask_q;
  assign pending = pending_q;
  assign overrun = overrun_q;

endmodule

// File: tb/tb_irq_ctrl.sv
// Bench for irq_ctrl with source 0 level-sensitive: directed scenarios plus random traffic vs a reference model.
module tb_irq_ctrl;

  localparam logic [7:0] LEVEL = 8'h01;
  localparam int S_IDLE = 0, S_REQ = 1, S_SERVICE = 2;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] src = '0;
  logic       in_kernel = 1'b0;
  logic       mask_we = 1'b0;
  logic [7:0] mask_wdata = '0;
  logic       irq_ack = 1'b0;
  logic       eoi = 1'b0;
  logic       irq;
  logic [2:0] irq_vec;
  logic [7:0] mask, pending, overrun;

  int checks = 0;
  int passes = 0;
  int fails  = 0;

  // Reference model state
  int         m_state;
  logic       m_irq;
  int         m_vec;
  logic [7:0] m_mask, m_pend, m_ovr, m_prev;

  irq_ctrl #(.NUM_SRC(8), .VEC_W(3), .LEVEL_MODE(LEVEL)) dut (
    .clk(clk), .reset(rst_n), .src(src), .in_kernel(in_kernel),
    .mask_we(mask_we), .mask_wdata(mask_wdata), .irq_ack(irq_ack), .eoi(eoi),
    .irq(irq), .irq_vec(irq_vec), .mask(mask), .pending(pending), .overrun(overrun)
  );

  always #5 clk = ~clk;

  task automatic model_clear();
    m_state = S_IDLE; m_irq = 1'b0; m_vec = 0;
    m_mask = '0; m_pend = '0; m_ovr = '0; m_prev = '0;
  endtask

  // One clock edge of the controller, from the written rules.
  task automatic model_step();
    logic [7:0] np, no;
    int  win;
    logic rs, served;
    win = -1;
    for (int i = 7; i >= 0; i--) if (m_pend[i] && m_mask[i]) win = i;
    for (int i = 0; i < 8; i++) begin
      rs     = src[i] && !m_prev[i];
      served = (m_state == S_REQ) && irq_ack && (m_vec == i);
      if (LEVEL[i]) begin np[i] = src[i]; no[i] = 1'b0; end
      else if (rs) begin np[i] = 1'b1; no[i] = served ? 1'b0 : (m_ovr[i] | m_pend[i]); end
      else if (served) begin np[i] = 1'b0; no[i] = 1'b0; end
      else begin np[i] = m_pend[i]; no[i] = m_ovr[i]; end
    end
    if (m_state == S_IDLE) begin
      if (win >= 0 && !in_kernel) begin m_state = S_REQ; m_irq = 1'b1; m_vec = win; end
    end else if (m_state == S_REQ) begin
      if (irq_ack) begin m_state = S_SERVICE; m_irq = 1'b0; end
      else if (!(m_pend[m_vec] && m_mask[m_vec])) begin m_state = S_IDLE; m_irq = 1'b0; end
    end else begin
      if (eoi) m_state = S_IDLE;
    end
    if (mask_we) m_mask = mask_wdata;
    m_pend = np; m_ovr = no; m_prev = src;
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; src = '0; in_kernel = 0; mask_we = 0; mask_wdata = '0; irq_ack = 0; eoi = 0;
    model_clear();
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  task automatic set_mask(input logic [7:0] v);
    mask_we = 1'b1; mask_wdata = v;
    tick();
    mask_we = 1'b0;
  endtask

  task automatic test_reset();
    @(posedge clk); #1;
    src = 8'hFF; rst_n = 1'b0;
    model_clear();
    @(posedge clk); @(posedge clk); #1;
    checks++; if (irq !== 1'b0) $display("FAIL rst_irq got %b want 0", irq); else passes++;
    checks++; if (irq_vec !== 3'd0) $display("FAIL rst_vec got %0d want 0", irq_vec); else passes++;
    checks++; if (mask !== 8'h00) $display("FAIL rst_mask got %h want 00", mask); else passes++;
    checks++; if (pending !== 8'h00) $display("FAIL rst_pend got %h want 00", pending); else passes++;
    checks++; if (overrun !== 8'h00) $display("FAIL rst_ovr got %h want 00", overrun); else passes++;
    rst_n = 1'b1;
    tick();
    checks++; if (pending !== 8'hFF) $display("FAIL rst_edges_pend got %h want ff", pending); else passes++;
    src = 8'h00;
    tick(); tick();
    checks++; if (pending !== 8'hFE) $display("FAIL rst_masked_pend got %h want fe", pending); else passes++;
    checks++; if (irq !== 1'b0) $display("FAIL rst_masked_irq got %b want 0", irq); else passes++;
  endtask

  task automatic test_basic_edge();
    do_reset();
    set_mask(8'hFF);
    src = 8'h08; tick(); src = 8'h00;
    checks++; if (pending !== 8'h08) $display("FAIL basic_pend got %h want 08", pending); else passes++;
    checks++; if (irq !== 1'b0) $display("FAIL basic_irq_early got %b want 0", irq); else passes++;
    tick();
    checks++; if (irq !== 1'b1 || irq_vec !== 3'd3) $display("FAIL basic_req got irq=%b vec=%0d want 1/3", irq, irq_vec); else passes++;
    irq_ack = 1'b1; tick(); irq_ack = 1'b0;
    checks++; if (pending !== 8'h00 || irq !== 1'b0) $display("FAIL basic_ack got pend=%h irq=%b want 00/0", pending, irq); else passes++;
    eoi = 1'b1; tick(); eoi = 1'b0; tick();
    checks++; if (irq !== 1'b0) $display("FAIL basic_eoi got irq=%b want 0", irq); else passes++;
  endtask

  task automatic test_priority();
    do_reset();
    set_mask(8'hFF);
    src = 8'h24; tick(); src = 8'h00; tick();
    checks++; if (irq !== 1'b1 || irq_vec !== 3'd2) $display("FAIL prio_first got irq=%b vec=%0d want 1/2", irq, irq_vec); else passes++;
    irq_ack = 1'b1; tick(); irq_ack = 1'b0;
    eoi = 1'b1; tick(); eoi = 1'b0; tick();
    checks++; if (irq !== 1'b1 || irq_vec !== 3'd5) $display("FAIL prio_second got irq=%b vec=%0d want 1/5", irq, irq_vec); else passes++;
  endtask

  task automatic test_kernel_mask();
    do_reset();
    set_mask(8'hFF);
    in_kernel = 1'b1;
    src = 8'h02; tick(); src = 8'h00; tick(); tick(); tick();
    checks++; if (irq !== 1'b0 || pending !== 8'h02) $display("FAIL kern_block got irq=%b pend=%h want 0/02", irq, pending); else passes++;
    in_kernel = 1'b0; tick();
    checks++; if (irq !== 1'b1 || irq_vec !== 3'd1) $display("FAIL kern_release got irq=%b vec=%0d want 1/1", irq, irq_vec); else passes++;
    in_kernel = 1'b1; tick(); in_kernel = 1'b0;
    checks++; if (irq !== 1'b1) $display("FAIL kern_in_req got irq=%b want 1", irq); else passes++;
    set_mask(8'hFD);
    checks++; if (irq !== 1'b1) $display("FAIL mask_hold got irq=%b want 1", irq); else passes++;
    tick();
    checks++; if (irq !== 1'b0 || pending !== 8'h02) $display("FAIL mask_drop got irq=%b pend=%h want 0/02", irq, pending); else passes++;
  endtask

  task automatic test_level();
    do_reset();
    set_mask(8'h01);
    src = 8'h01; tick(); tick();
    checks++; if (irq !== 1'b1 || irq_vec !== 3'd0) $display("FAIL lvl_req got irq=%b vec=%0d want 1/0", irq, irq_vec); else passes++;
    irq_ack = 1'b1; tick(); irq_ack = 1'b0;
    checks++; if (irq !== 1'b0 || pending !== 8'h01) $display("FAIL lvl_ack got irq=%b pend=%h want 0/01", irq, pending); else passes++;
    tick(); tick();
    checks++; if (irq !== 1'b0) $display("FAIL lvl_service got irq=%b want 0", irq); else passes++;
    eoi = 1'b1; tick(); eoi = 1'b0;
    checks++; if (irq !== 1'b0) $display("FAIL lvl_eoi got irq=%b want 0", irq); else passes++;
    tick();
    checks++; if (irq !== 1'b1) $display("FAIL lvl_rereq got irq=%b want 1", irq); else passes++;
    irq_ack = 1'b1; tick(); irq_ack = 1'b0;
    src = 8'h00; tick();
    eoi = 1'b1; tick(); eoi = 1'b0; tick(); tick();
    checks++; if (irq !== 1'b0 || pending !== 8'h00 || overrun !== 8'h00) $display("FAIL lvl_release got irq=%b pend=%h ovr=%h want 0/00/00", irq, pending, overrun); else passes++;
  endtask

  task automatic test_overrun();
    do_reset();
    set_mask(8'hFF);
    src = 8'h10; tick(); src = 8'h00; tick();
    src = 8'h10; tick(); src = 8'h00;
    checks++; if (overrun !== 8'h10 || pending !== 8'h10 || irq !== 1'b1) $display("FAIL ovr_set got ovr=%h pend=%h irq=%b want 10/10/1", overrun, pending, irq); else passes++;
    irq_ack = 1'b1; tick(); irq_ack = 1'b0;
    checks++; if (overrun !== 8'h00 || pending !== 8'h00) $display("FAIL ovr_ack got ovr=%h pend=%h want 00/00", overrun, pending); else passes++;
    eoi = 1'b1; tick(); eoi = 1'b0;
    src = 8'h10; tick(); src = 8'h00; tick();
    checks++; if (irq !== 1'b1 || irq_vec !== 3'd4) $display("FAIL coll_req got irq=%b vec=%0d want 1/4", irq, irq_vec); else passes++;
    irq_ack = 1'b1; src = 8'h10; tick(); irq_ack = 1'b0; src = 8'h00;
    checks++; if (pending !== 8'h10 || overrun !== 8'h00 || irq !== 1'b0) $display("FAIL coll_ack got pend=%h ovr=%h irq=%b want 10/00/0", pending, overrun, irq); else passes++;
    eoi = 1'b1; tick(); eoi = 1'b0; tick();
    checks++; if (irq !== 1'b1 || irq_vec !== 3'd4) $display("FAIL coll_rereq got irq=%b vec=%0d want 1/4", irq, irq_vec); else passes++;
  endtask

  task automatic test_reset_mid();
    do_reset();
    set_mask(8'hFF);
    src = 8'h40; tick(); src = 8'h00; tick();
    checks++; if (irq !== 1'b1 || irq_vec !== 3'd6) $display("FAIL midrst_req got irq=%b vec=%0d want 1/6", irq, irq_vec); else passes++;
    #2 rst_n = 1'b0; #1;
    checks++; if (irq !== 1'b0 || pending !== 8'h00 || mask !== 8'h00 || irq_vec !== 3'd0) $display("FAIL midrst_async got irq=%b pend=%h mask=%h vec=%0d want 0/00/00/0", irq, pending, mask, irq_vec); else passes++;
    model_clear();
    @(posedge clk); #1; rst_n = 1'b1;
    set_mask(8'hFF); tick(); tick();
    checks++; if (irq !== 1'b0 || pending !== 8'h00) $display("FAIL midrst_lost got irq=%b pend=%h want 0/00", irq, pending); else passes++;
  endtask

  task automatic test_random();
    int bad = 0;
    do_reset();
    for (int c = 0; c < 800; c++) begin
      src        = src ^ (8'($urandom) & 8'($urandom) & 8'($urandom));
      in_kernel  = ($urandom_range(0, 3) == 0);
      irq_ack    = m_irq ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 9) == 0);
      eoi        = ($urandom_range(0, 4) == 0);
      mask_we    = ($urandom_range(0, 11) == 0);
      mask_wdata = 8'($urandom);
      tick();
      checks++;
      if (irq !== m_irq || irq_vec !== 3'(m_vec) || mask !== m_mask || pending !== m_pend || overrun !== m_ovr) begin
        bad++;
        if (bad <= 10)
          $display("FAIL rand_cyc%0d got irq=%b vec=%0d mask=%h pend=%h ovr=%h want irq=%b vec=%0d mask=%h pend=%h ovr=%h",
                   c, irq, irq_vec, mask, pending, overrun, m_irq, m_vec, m_mask, m_pend, m_ovr);
      end else passes++;
    end
    irq_ack = 0; eoi = 0; mask_we = 0; in_kernel = 0;
  endtask

  initial begin
    model_clear();
    test_reset();
    test_basic_edge();
    test_priority();
    test_kernel_mask();
    test_level();
    test_overrun();
    test_reset_mid();
    test_random();
    fails = checks - passes;
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
